mrd_seq_ctrl: RTL and testbench
===============================

Name: mrd_seq_ctrl

Overview:
- Phase sequencer for the MRD detector datapath: pre-processing (Gram matrix A and vector b), then MRD initial-inverse refinement, then M·b generation, then N passes of the iteration unit.
- Drives one enable per stage, each for a fixed programmable number of cycles.
- Counts detector iterations and captures the final estimate x_final into a holding register.
- Gives the host a start/busy/done handshake, plus abort and a parameter-error report.

Parameters:
- DIMENSION, 16, vector length (number of elements).
- WIDTH, 8, bits per element.
- PRE_LAT, 8, cycles pre_en is held high (pre-processing latency).
- INV_LAT, 20, cycles inv_en is held high (MRD inverse refinement).
- MB_LAT, 4, cycles mb_en is held high (M·b generation).
- ITER_LAT, 6, cycles per detector iteration.
- MAX_ITER, 8, largest legal n_iter value.
- CNT_W, 8, phase-counter width; must hold the largest of the *_LAT values minus 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a detection run; sampled only in IDLE.
- n_iter  in  4  iteration count, legal range 1..MAX_ITER; sampled together with start.
- abort  in  1  cancel the run in progress.
- pre_en  out  1  enable for the pre-processing stage.
- inv_en  out  1  enable for the MRD inverse stage.
- mb_en  out  1  enable for the M·b generator.
- iter_en  out  1  enable for the iteration unit.
- iter_load  out  1  iteration unit selects x0 (not feedback); high only in the first cycle of iteration 0.
- iter_idx  out  4  index of the current iteration, starting at 0.
- x_in  in  DIMENSION*WIDTH  x_final from the iteration unit.
- x_out  out  DIMENSION*WIDTH  captured result.
- busy  out  1  high in PRE, INV, MB and ITER.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when start is given with an illegal n_iter.

Behaviour:
- Reset: state IDLE; every output 0, x_out included; phase counter and iteration counter 0.
- State machine is IDLE -> PRE -> INV -> MB -> ITER -> DONE -> IDLE.
- All outputs are registered or decoded from the registered state; there is no combinational path from any input to any output.
- On entry to each phase the counter loads LAT-1. It decrements once per cycle, and the phase exits when the counter is 0.
- Each enable is therefore high for exactly its LAT cycles. Enables are mutually exclusive and there is no gap cycle between phases.
- In IDLE, start=1 with 1<=n_iter<=MAX_ITER: n_iter is latched and the block enters PRE at the next edge.
- In IDLE, start=1 with n_iter=0 or n_iter>MAX_ITER: err=1 for one cycle and the block stays IDLE.
- start is ignored outside IDLE; the latched n_iter does not change mid-run.
- ITER runs n_iter passes of ITER_LAT cycles each.
  - iter_en stays high continuously for the whole ITER state.
  - iter_idx increments when each pass wraps its counter.
  - When the counter reaches 0 on pass n_iter-1, the block moves to DONE and x_out <= x_in on that same edge.
- DONE lasts one cycle: done=1 and busy=0, then the block returns to IDLE.
- x_out holds its value until the next successful completion.
- Total time from the start edge to done = PRE_LAT + INV_LAT + MB_LAT + n_iter*ITER_LAT + 1 cycles.
- abort=1 in any busy state: IDLE at the next edge; all enables and iter_idx go to 0; no done pulse; x_out unchanged.
- abort in IDLE or DONE has no effect; the DONE pulse still completes.
- abort and start together in IDLE: start is still evaluated. abort affects only runs in progress.
- start high during the DONE cycle is ignored; the next run needs start in IDLE.
- Asynchronous reset mid-run clears everything immediately, x_out included.

Test Plan:
- Defaults, n_iter=3, start sampled at edge 0:
  - pre_en high cycles 1-8, inv_en 9-28, mb_en 29-32, iter_en 33-50.
  - iter_load only at cycle 33; iter_idx=0,1,2 at cycles 33,39,45.
  - done at cycle 51; x_out equals the x_in value sampled at edge 50; busy high cycles 1-50.
- start with n_iter=0, then with n_iter=9 -> err pulse one cycle each; no enable ever rises; busy stays 0.
- abort at cycle 20 during INV (n_iter=2) -> all enables 0 from cycle 21; no done; x_out keeps its previous value; a new start at cycle 25 gives done at cycle 25+44+1.
- start held high continuously with n_iter=1:
  - Back-to-back runs, each 39 cycles long.
  - done spaced 40 cycles apart (includes the DONE cycle and one IDLE cycle).
  - No start is accepted during a run.
- Assert rst low during ITER -> all outputs 0 asynchronously, before the next clock edge; after release, a normal run completes.
- n_iter=MAX_ITER=8 -> iter_idx runs 0..7; iter_en high for 48 continuous cycles; done at cycle 81.

Source files
------------

// File: rtl/mrd_seq_if.sv
// Host/stage bundle for the MRD detector phase sequencer.
// The slave side belongs to the sequencer; the master side belongs to the host and datapath.
interface mrd_seq_if #(
   parameter int DIMENSION = 16,
   parameter int WIDTH     = 8
);
   logic                       start;
   logic [3:0]                 n_iter;
   logic                       abort;
   logic                       pre_en;
   logic                       inv_en;
   logic                       mb_en;
   logic                       iter_en;
   logic                       iter_load;
   logic [3:0]                 iter_idx;
   logic [DIMENSION*WIDTH-1:0] x_in;
   logic [DIMENSION*WIDTH-1:0] x_out;
   logic                       busy;
   logic                       done;
   logic                       err;

   modport master (
      output start, n_iter, abort, x_in,
      input  pre_en, inv_en, mb_en, iter_en, iter_load, iter_idx, x_out, busy, done, err
   );

   modport slave (
      input  start, n_iter, abort, x_in,
      output pre_en, inv_en, mb_en, iter_en, iter_load, iter_idx, x_out, busy, done, err
   );
endinterface

// File: rtl/mrd_seq_ctrl.sv
// Phase sequencer for the MRD detector: PRE -> INV -> MB -> n_iter x ITER, then captures x_final.
//
// state  | meaning
// IDLE   | waiting for a legal start
// PRE    | Gram matrix / b pre-processing, PRE_LAT cycles
// INV    | MRD inverse refinement, INV_LAT cycles
// MB     | M*b generation, MB_LAT cycles
// ITER   | n_iter passes of ITER_LAT cycles, iter_en held continuously
// DONE   | single-cycle completion pulse
module mrd_seq_ctrl #(
   parameter int DIMENSION = 16,
   parameter int WIDTH     = 8,
   parameter int PRE_LAT   = 8,
   parameter int INV_LAT   = 20,
   parameter int MB_LAT    = 4,
   parameter int ITER_LAT  = 6,
   parameter int MAX_ITER  = 8,
   parameter int CNT_W     = 8
) (
   input  logic      clk,
   input  logic      rst,
   mrd_seq_if.slave  bus
);
   typedef enum logic [2:0] {S_IDLE, S_PRE, S_INV, S_MB, S_ITER, S_DONE} state_t;

   localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_LAT - 1);
   localparam logic [CNT_W-1:0] INV_LD  = CNT_W'(INV_LAT - 1);
   localparam logic [CNT_W-1:0] MB_LD   = CNT_W'(MB_LAT - 1);
   localparam logic [CNT_W-1:0] ITER_LD = CNT_W'(ITER_LAT - 1);
   localparam logic [3:0]       MAX_N   = 4'(MAX_ITER);

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [3:0]                 iter_q, iter_d;
   logic [3:0]                 n_q, n_d;
   logic                       err_q, err_d;
   logic [DIMENSION*WIDTH-1:0] x_q, x_d;
   logic                       cnt_zero;
   logic                       n_legal;
   logic                       running;

   assign cnt_zero = (cnt_q == '0);
   assign n_legal  = (bus.n_iter != 4'd0) && (bus.n_iter <= MAX_N);
   assign running  = (state_q == S_PRE) || (state_q == S_INV) ||
                     (state_q == S_MB)  || (state_q == S_ITER);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         iter_q  <= '0;
         n_q     <= '0;
         err_q   <= 1'b0;
         x_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         iter_q  <= iter_d;
         n_q     <= n_d;
         err_q   <= err_d;
         x_q     <= x_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      iter_d  = iter_q;
      n_d     = n_q;
      err_d   = 1'b0;
      x_d     = x_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (n_legal) begin
                  n_d     = bus.n_iter;
                  cnt_d   = PRE_LD;
                  iter_d  = '0;
                  state_d = S_PRE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_PRE: begin
            if (cnt_zero) begin
               cnt_d   = INV_LD;
               state_d = S_INV;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_INV: begin
            if (cnt_zero) begin
               cnt_d   = MB_LD;
               state_d = S_MB;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_MB: begin
            if (cnt_zero) begin
               cnt_d   = ITER_LD;
               iter_d  = '0;
               state_d = S_ITER;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_ITER: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (iter_q == 4'(n_q - 4'd1)) begin
               x_d     = bus.x_in;
               iter_d  = '0;
               state_d = S_DONE;
            end else begin
               iter_d = iter_q + 4'd1;
               cnt_d  = ITER_LD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            iter_d  = '0;
         end
      endcase
      // Abort wins over any phase transition, including the final capture.
      if (bus.abort && running) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         iter_d  = '0;
         x_d     = x_q;
      end
   end

   assign bus.pre_en    = (state_q == S_PRE);
   assign bus.inv_en    = (state_q == S_INV);
   assign bus.mb_en     = (state_q == S_MB);
   assign bus.iter_en   = (state_q == S_ITER);
   assign bus.iter_load = (state_q == S_ITER) && (iter_q == 4'd0) && (cnt_q == ITER_LD);
   assign bus.iter_idx  = iter_q;
   assign bus.busy      = running;
   assign bus.done      = (state_q == S_DONE);
   assign bus.err       = err_q;
   assign bus.x_out     = x_q;
endmodule

// File: tb/tb_mrd_seq_ctrl.sv
// Directed bench for mrd_seq_ctrl: phase timing, iteration indexing, capture, err, abort and reset.
module tb_mrd_seq_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cur_cyc = 0;
   logic [127:0] exp_x = '0;

   always #5 clk = ~clk;

   mrd_seq_if #(.DIMENSION(16), .WIDTH(8)) bus ();

   mrd_seq_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [127:0] xpat(input int k, input logic [127:0] seed);
      logic [7:0] b;
      b = 8'(k);
      return seed ^ {16{b}};
   endfunction

   function automatic logic [7:0] flags();
      return {bus.pre_en, bus.inv_en, bus.mb_en, bus.iter_en,
              bus.iter_load, bus.busy, bus.done, bus.err};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cur_cyc, obs, expv);
      end
   endtask

   // Start sampled at the coming edge (edge 0); cycle k lies between edge k-1 and edge k.
   task automatic run_normal(input logic [3:0] n, input int abort_at,
                             input logic [127:0] seed, input bit abort_with_start);
      int it_end, done_c, last, rel;
      logic act;
      logic [7:0] ef;
      logic [3:0] eidx;
      it_end = 32 + 6 * int'(n);
      done_c = it_end + 1;
      last   = (abort_at > 0) ? abort_at + 5 : done_c + 1;
      bus.start  = 1'b1;
      bus.n_iter = n;
      bus.abort  = abort_with_start;
      bus.x_in   = xpat(0, seed);
      for (int k = 1; k <= last; k++) begin
         @(posedge clk); #1;
         cur_cyc   = k;
         bus.start = 1'b0;
         bus.abort = 1'b0;
         if (abort_at == 0 && k == done_c) exp_x = xpat(it_end, seed);
         act  = (abort_at == 0) || (k <= abort_at);
         rel  = k;
         ef   = '0;
         eidx = '0;
         if (act) begin
            ef[7] = (rel >= 1  && rel <= 8);
            ef[6] = (rel >= 9  && rel <= 28);
            ef[5] = (rel >= 29 && rel <= 32);
            ef[4] = (rel >= 33 && rel <= it_end);
            ef[3] = (rel == 33);
            ef[2] = (rel >= 1  && rel <= it_end);
            ef[1] = (rel == done_c);
            if (ef[4]) eidx = 4'((rel - 33) / 6);
         end
         chk("flags", 128'(flags()), 128'(ef));
         chk("iter_idx", 128'(bus.iter_idx), 128'(eidx));
         chk("x_out", bus.x_out, exp_x);
         if (k == abort_at) bus.abort = 1'b1;
         bus.x_in = xpat(k, seed);
      end
   endtask

   initial begin
      int rel, r;
      logic [7:0] ef;
      bus.start  = 1'b0;
      bus.n_iter = 4'd0;
      bus.abort  = 1'b0;
      bus.x_in   = '0;

      #12;
      chk("reset_flags", 128'(flags()), 128'd0);
      chk("reset_idx", 128'(bus.iter_idx), 128'd0);
      chk("reset_x_out", bus.x_out, 128'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      run_normal(4'd3, 0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1'b0);

      // Illegal n_iter: err pulses, nothing else moves.
      bus.start = 1'b1; bus.n_iter = 4'd0;
      @(posedge clk); #1;
      chk("err_n0", 128'(flags()), 128'h01);
      bus.n_iter = 4'd9;
      @(posedge clk); #1;
      chk("err_n9", 128'(flags()), 128'h01);
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("err_quiet", 128'(flags()), 128'h00);
         chk("err_x_out", bus.x_out, exp_x);
      end

      run_normal(4'd2, 20, 128'h5555_aaaa_5555_aaaa_1111_2222_3333_4444, 1'b0);
      run_normal(4'd2, 0, 128'hdead_beef_cafe_f00d_0bad_c0de_1234_5678, 1'b1);

      // start held high: back-to-back n_iter=1 runs, done every 40 cycles.
      bus.start = 1'b1; bus.n_iter = 4'd1;
      bus.x_in  = xpat(0, 128'h0f0f_0f0f_f0f0_f0f0_3c3c_3c3c_c3c3_c3c3);
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk); #1;
         cur_cyc = k;
         r   = (k - 1) / 40;
         rel = k - 40 * r;
         if (rel == 39) exp_x = xpat(k - 1, 128'h0f0f_0f0f_f0f0_f0f0_3c3c_3c3c_c3c3_c3c3);
         ef    = '0;
         ef[7] = (rel >= 1  && rel <= 8);
         ef[6] = (rel >= 9  && rel <= 28);
         ef[5] = (rel >= 29 && rel <= 32);
         ef[4] = (rel >= 33 && rel <= 38);
         ef[3] = (rel == 33);
         ef[2] = (rel >= 1  && rel <= 38);
         ef[1] = (rel == 39);
         chk("b2b_flags", 128'(flags()), 128'(ef));
         chk("b2b_x_out", bus.x_out, exp_x);
         if (k == 79) bus.start = 1'b0;
         bus.x_in = xpat(k, 128'h0f0f_0f0f_f0f0_f0f0_3c3c_3c3c_c3c3_c3c3);
      end

      // Asynchronous reset in the middle of ITER.
      bus.start = 1'b1; bus.n_iter = 4'd3;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      cur_cyc = 40;
      chk("pre_rst_iter_en", 128'(bus.iter_en), 128'd1);
      #2 rst = 1'b0;
      #1;
      exp_x = '0;
      chk("async_rst_flags", 128'(flags()), 128'd0);
      chk("async_rst_idx", 128'(bus.iter_idx), 128'd0);
      chk("async_rst_x_out", bus.x_out, 128'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      run_normal(4'd1, 0, 128'h7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee, 1'b0);
      run_normal(4'd8, 0, 128'h1357_9bdf_2468_ace0_1357_9bdf_2468_ace0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cur_cyc);
      $fatal(1, "time limit");
   end
endmodule
